// File: rtl/serial_adder_seq.sv
`default_nettype none
// ============================================================================
//  Module      : serial_adder_seq
//  Description : Bit-serial ripple adder. Captures two WIDTH-bit operands on a
//                START pulse, adds one bit per clock through a single full-adder
//                cell plus a carry flip-flop, then presents the registered sum
//                and carry-out together with a one-cycle DONE pulse.
//                Optional build macro SERIAL_ADDER_SUB_EN adds a SUB input that
//                turns the operation into A - B (A + ~B + 1).
//  Revision    : 1.0 - initial release
// ============================================================================
module serial_adder_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             start_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             cin_i,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub_i,
`endif
    output logic [WIDTH-1:0] sum_o,
    output logic             cout_o,
    output logic             busy_o,
    output logic             done_o
);

    // Counter only has to reach WIDTH-1, so clog2(WIDTH) bits suffice.
    localparam int                CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIN  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_sr_q,  a_sr_d;
    logic [WIDTH-1:0]   b_sr_q,  b_sr_d;
    logic [WIDTH-1:0]   s_sr_q,  s_sr_d;
    logic               c_q,     c_d;
    logic [CNT_W-1:0]   cnt_q,   cnt_d;
    logic [WIDTH-1:0]   sum_q,   sum_d;
    logic               cout_q,  cout_d;
    logic               busy_q,  busy_d;
    logic               done_q,  done_d;

    // Values loaded on an accepting edge; subtraction feeds ~B with carry 1.
    logic [WIDTH-1:0]   w_b_load;
    logic               w_c_load;

`ifdef SERIAL_ADDER_SUB_EN
    assign w_b_load = sub_i ? ~b_i : b_i;
    assign w_c_load = sub_i ? 1'b1 : cin_i;
`else
    assign w_b_load = b_i;
    assign w_c_load = cin_i;
`endif

    // The single full-adder cell working on the current LSBs.
    logic w_s;
    logic w_carry;
    assign w_s     = a_sr_q[0] ^ b_sr_q[0] ^ c_q;
    assign w_carry = (a_sr_q[0] & b_sr_q[0]) | (a_sr_q[0] & c_q) | (b_sr_q[0] & c_q);

    // The LSB of the sum shift register falls off on every shift and is never
    // part of a result; tie it to a sink so it is visibly intentional.
    logic w_unused_s_lsb;
    assign w_unused_s_lsb = s_sr_q[0];

    // Next-state, datapath and registered-output decode for the serial FSM.
    always_comb begin
        state_d = state_q;
        a_sr_d  = a_sr_q;
        b_sr_d  = b_sr_q;
        s_sr_d  = s_sr_q;
        c_d     = c_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        busy_d  = 1'b0;
        done_d  = 1'b0;

        case (state_q)
            ST_IDLE, ST_FIN: begin
                // FIN behaves like IDLE for acceptance, giving back-to-back starts.
                if (start_i) begin
                    a_sr_d  = a_i;
                    b_sr_d  = w_b_load;
                    c_d     = w_c_load;
                    cnt_d   = '0;
                    state_d = ST_RUN;
                    busy_d  = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_RUN: begin
                // One bit per cycle; START is ignored while running.
                a_sr_d = {1'b0, a_sr_q[WIDTH-1:1]};
                b_sr_d = {1'b0, b_sr_q[WIDTH-1:1]};
                s_sr_d = {w_s, s_sr_q[WIDTH-1:1]};
                c_d    = w_carry;
                if (cnt_q == CNT_LAST) begin
                    // Publish only the complete result; counter holds, never wraps.
                    sum_d   = {w_s, s_sr_q[WIDTH-1:1]};
                    cout_d  = w_carry;
                    state_d = ST_FIN;
                    done_d  = 1'b1;
                end else begin
                    cnt_d  = cnt_q + CNT_W'(1);
                    busy_d = 1'b1;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, datapath and output registers; async reset aborts any computation.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= ST_IDLE;
            a_sr_q  <= '0;
            b_sr_q  <= '0;
            s_sr_q  <= '0;
            c_q     <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_sr_q  <= a_sr_d;
            b_sr_q  <= b_sr_d;
            s_sr_q  <= s_sr_d;
            c_q     <= c_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign sum_o  = sum_q;
    assign cout_o = cout_q;
    assign busy_o = busy_q;
    assign done_o = done_q;

endmodule
`default_nettype wire

// File: tb/tb_serial_adder_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_serial_adder_seq
//  Description : Directed self-checking bench for serial_adder_seq (WIDTH=8).
//                Exercises SUB tests when SERIAL_ADDER_SUB_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_adder_seq;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic       sub;
    logic [7:0] sum;
    logic       cout;
    logic       busy;
    logic       done;

    int checks   = 0;
    int failures = 0;

    logic [7:0] last_sum;
    logic       seen_done;

    always #5 clk = ~clk;

    serial_adder_seq #(.WIDTH(8)) dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .start_i (start),
        .a_i     (a),
        .b_i     (b),
        .cin_i   (cin),
`ifdef SERIAL_ADDER_SUB_EN
        .sub_i   (sub),
`endif
        .sum_o   (sum),
        .cout_o  (cout),
        .busy_o  (busy),
        .done_o  (done)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] opa(input int i);
        logic [31:0] t;
        t = i * 37 + 5;
        return t[7:0];
    endfunction

    function automatic logic [7:0] opb(input int i);
        logic [31:0] t;
        t = i * 91 + 17;
        return t[7:0];
    endfunction

    function automatic logic [8:0] ref_add(input int i);
        return {1'b0, opa(i)} + {1'b0, opb(i)} + {8'd0, i[0]};
    endfunction

    // One full operation: start, 8 RUN cycles, FIN. Optionally pokes START
    // with junk operands during RUN, which must be ignored.
    task automatic do_op(input string tag, input logic [7:0] ta, input logic [7:0] tb_v,
                         input logic tcin, input logic tsub, input logic noise,
                         input logic [7:0] hold, input logic [7:0] esum, input logic ecout);
        @(negedge clk);
        start = 1'b1; a = ta; b = tb_v; cin = tcin; sub = tsub;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            chk({tag, "_busy"}, busy, 1);
            chk({tag, "_nodone"}, done, 0);
            chk({tag, "_hold"}, sum, hold);
            if (noise) begin
                start = 1'b1;
                a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom);
            end else begin
                start = 1'b0;
            end
        end
        @(negedge clk);
        start = 1'b0;
        chk({tag, "_done"}, done, 1);
        chk({tag, "_busy_fin"}, busy, 0);
        chk({tag, "_sum"}, sum, esum);
        chk({tag, "_cout"}, cout, ecout);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_sum", sum, 0);
        chk("rst_cout", cout, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        rst_n = 1'b1;

        // Basic add, then result must persist.
        do_op("t5a33", 8'h5A, 8'h33, 1'b0, 1'b0, 1'b0, 8'h00, 8'h8D, 1'b0);
        @(negedge clk);
        chk("t5a33_pulse", done, 0);
        chk("t5a33_persist", sum, 8'h8D);

        do_op("tff01", 8'hFF, 8'h01, 1'b0, 1'b0, 1'b1, 8'h8D, 8'h00, 1'b1);
        do_op("tcin", 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 8'h01, 1'b0);

        // START held high with changing operands: accepted at k=0,9,18 only.
        for (int k = 0; k <= 27; k++) begin
            @(negedge clk);
            if (k > 0) begin
                chk("b2b_done", done, (k % 9 == 0) ? 1 : 0);
                if (k % 9 == 0) begin
                    chk("b2b_sum", sum, {24'd0, ref_add(k - 9)} & 32'hFF);
                    chk("b2b_cout", cout, ref_add(k - 9) >> 8);
                end
            end
            start = (k < 20);
            a = opa(k); b = opb(k); cin = k[0];
        end
        start = 1'b0;
        last_sum = ref_add(18) & 9'h0FF;

        // Reset asserted during the 4th RUN cycle aborts the computation.
        @(negedge clk);
        start = 1'b1; a = 8'h5A; b = 8'h33; cin = 1'b0;
        repeat (3) begin
            @(negedge clk);
            start = 1'b0;
        end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_sum", sum, 0);
        chk("abort_cout", cout, 0);
        @(negedge clk);
        rst_n = 1'b1;
        seen_done = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (done) seen_done = 1'b1;
        end
        chk("abort_no_done", seen_done, 0);
        do_op("after_abort", 8'h5A, 8'h33, 1'b0, 1'b0, 1'b0, 8'h00, 8'h8D, 1'b0);
        last_sum = 8'h8D;

`ifdef SERIAL_ADDER_SUB_EN
        do_op("sub_5_7", 8'h05, 8'h07, 1'b0, 1'b1, 1'b0, last_sum, 8'hFE, 1'b0);
        do_op("sub_7_5", 8'h07, 8'h05, 1'b1, 1'b1, 1'b0, 8'hFE, 8'h02, 1'b1);
        do_op("sub0_add", 8'h10, 8'h20, 1'b1, 1'b0, 1'b0, 8'h02, 8'h31, 1'b0);
        last_sum = 8'h31;
`endif

        // Randomized sweep against a plain 9-bit addition model.
        for (int n = 0; n < 40; n++) begin
            logic [7:0] ra;
            logic [7:0] rb;
            logic       rc;
            logic [8:0] rexp;
            int         gap;
            ra   = 8'($urandom);
            rb   = 8'($urandom);
            rc   = 1'($urandom);
            rexp = {1'b0, ra} + {1'b0, rb} + {8'd0, rc};
            gap  = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) begin
                @(negedge clk);
                chk("rnd_idle_done", done, 0);
            end
            do_op("rnd", ra, rb, rc, 1'b0, 1'($urandom), last_sum, rexp[7:0], rexp[8]);
            last_sum = rexp[7:0];
        end

        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
